// File: rtl/bf16_vector_capture_if.sv
// rtl/bf16_vector_capture_if.sv - record input stream and memory write port of the BF16 vector capture block
//
// Signals:
//   in_valid/in_ready          record handshake (master offers, slave accepts)
//   in_a/in_b/in_result        BF16 operand A, operand B, multiplier result
//   in_flags                   {Exception, Overflow, Underflow}
//   mem_we/mem_ready           memory write request and acceptance
//   mem_addr                   record index being written
//   mem_wdata                  {a, b, result} record word
// Modports: master = record source and memory, slave = capture block.

interface bf16_vector_capture_if #(
    parameter int ADDR_W = 14
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_a;
    logic [15:0]       in_b;
    logic [15:0]       in_result;
    logic [2:0]        in_flags;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [47:0]       mem_wdata;

    modport master (
        output in_valid, in_a, in_b, in_result, in_flags, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_a, in_b, in_result, in_flags, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/bf16_vector_capture.sv
// rtl/bf16_vector_capture.sv - captures N_VEC multiplier records through a FIFO into sequential memory addresses
//
// Ports:
//   clk       single clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     single-cycle run request (honoured in IDLE or DONE only)
//   bus       slave side of bf16_vector_capture_if (record stream in, memory writes out)
//   busy      run in progress (CAPTURE or DRAIN)
//   done      run completed, held until the next start
//   flag_cnt  accepted records with any flag bit set, saturating
//
// DEPTH must be a power of two, at least 2; N_VEC <= 2**ADDR_W.

module bf16_vector_capture #(
    parameter int N_VEC  = 10000,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    bf16_vector_capture_if.slave   bus,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W:0]        flag_cnt
);
    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [ADDR_W:0] N_TOTAL  = (ADDR_W+1)'(N_VEC);
    localparam logic [ADDR_W:0] N_LAST   = (ADDR_W+1)'(N_VEC - 1);
    localparam logic [PTR_W:0]  LVL_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]  LVL_ONE  = (PTR_W+1)'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state;
    logic [47:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    level;
    logic [ADDR_W:0]   acc_cnt;
    logic [ADDR_W-1:0] wr_addr;

    logic full;
    logic empty;
    logic active;
    logic push;
    logic pop;

    assign full   = (level == LVL_FULL);
    assign empty  = (level == '0);
    assign active = (state == CAPTURE) || (state == DRAIN);

    // Handshake outputs depend on registered state only; full blocks a push
    // even when a pop happens in the same cycle.
    assign bus.in_ready  = (state == CAPTURE) && !full && (acc_cnt < N_TOTAL);
    assign bus.mem_we    = active && !empty;
    assign bus.mem_addr  = wr_addr;
    // Gated so the data bus reads zero whenever no write is offered,
    // independent of the unreset FIFO storage.
    assign bus.mem_wdata = bus.mem_we ? fifo_mem[rd_ptr] : '0;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.mem_we && bus.mem_ready;

    assign busy = active;
    assign done = (state == DONE);

    // Storage only; a record written here is first visible on the next cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.in_a, bus.in_b, bus.in_result};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            acc_cnt  <= '0;
            wr_addr  <= '0;
            flag_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= CAPTURE;
                        rd_ptr   <= '0;
                        wr_ptr   <= '0;
                        level    <= '0;
                        acc_cnt  <= '0;
                        wr_addr  <= '0;
                        flag_cnt <= '0;
                    end
                end
                CAPTURE, DRAIN: begin
                    if (push) begin
                        wr_ptr  <= wr_ptr + 1'b1;
                        acc_cnt <= acc_cnt + 1'b1;
                        if ((bus.in_flags != 3'b000) && (flag_cnt != '1)) begin
                            flag_cnt <= flag_cnt + 1'b1;
                        end
                    end
                    if (pop) begin
                        rd_ptr  <= rd_ptr + 1'b1;
                        wr_addr <= wr_addr + 1'b1;
                    end
                    case ({push, pop})
                        2'b10:   level <= level + 1'b1;
                        2'b01:   level <= level - 1'b1;
                        default: level <= level;
                    endcase
                    // The last accept always leaves at least one record
                    // buffered, so DRAIN is never entered empty.
                    if ((state == CAPTURE) && push && (acc_cnt == N_LAST)) begin
                        state <= DRAIN;
                    end
                    if ((state == DRAIN) && pop && (level == LVL_ONE)) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/bf16_vector_capture.md
BF16_VECTOR_CAPTURE -- requirements
Module: bf16_vector_capture

Interface
REQ-001 SHALL have parameter N_VEC, default 10000: number of records captured per run.
REQ-002 SHALL have parameter DEPTH, default 8: internal FIFO depth in records, a power of two.
REQ-003 SHALL have parameter ADDR_W, default 14: memory address width; N_VEC <= 2**ADDR_W.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: single-cycle run request.
REQ-007 SHALL have port in_valid, input, 1: an operand/result record is offered.
REQ-008 SHALL have port in_ready, output, 1: the block accepts the offered record.
REQ-009 SHALL have ports in_a, in_b, in_result, input, 16 each: BF16 operand A, operand B, and multiplier result.
REQ-010 SHALL have port in_flags, input, 3: {Exception, Overflow, Underflow} from the multiplier.
REQ-011 SHALL have port mem_we, output, 1: memory write request.
REQ-012 SHALL have port mem_ready, input, 1: the memory accepts the write this cycle.
REQ-013 SHALL have port mem_addr, output, ADDR_W: record index being written.
REQ-014 SHALL have port mem_wdata, output, 48: record {a[47:32], b[31:16], result[15:0]}, the same layout as the checker's test-vector words.
REQ-015 SHALL have port busy, output, 1: a run is in progress.
REQ-016 SHALL have port done, output, 1: the run has completed.
REQ-017 SHALL have port flag_cnt, output, ADDR_W+1: number of accepted records with any in_flags bit set.

Function
REQ-018 SHALL implement states IDLE, CAPTURE, DRAIN and DONE.
REQ-019 SHALL, on start in IDLE or DONE, go to CAPTURE next cycle, clearing the accept count, write address, flag_cnt and done, and emptying the FIFO.
REQ-020 SHALL ignore start in CAPTURE and DRAIN.
REQ-021 SHALL drive in_ready = (state==CAPTURE) && FIFO not full && accept count < N_VEC, combinationally from registered state only.
REQ-022 SHALL push {in_a,in_b,in_result} into the FIFO and increment the accept count on each cycle where in_valid && in_ready.
REQ-023 SHALL increment flag_cnt on an accept when in_flags != 0, saturating at all-ones.
REQ-024 SHALL not push when the FIFO is full, even if a pop occurs in the same cycle.
REQ-025 SHALL drive mem_we = FIFO not empty && state in {CAPTURE, DRAIN}, with mem_wdata = FIFO head and mem_addr = write address.
REQ-026 SHALL pop the FIFO and increment the write address on mem_we && mem_ready.
REQ-027 SHALL hold mem_we, mem_addr and mem_wdata stable while mem_we && !mem_ready.
REQ-028 SHALL support a push and a pop in the same cycle whenever the FIFO is neither full nor empty, leaving the FIFO level unchanged.
REQ-029 SHALL make a record accepted in cycle t visible on mem_wdata at the earliest in cycle t+1, with no bypass path.
REQ-030 SHALL go from CAPTURE to DRAIN on the cycle after the N_VEC-th accept.
REQ-031 SHALL go from DRAIN to DONE on the cycle after the pop that empties the FIFO.
REQ-032 SHALL drive busy = (state==CAPTURE || state==DRAIN).
REQ-033 SHALL drive done = (state==DONE), held until the next start.
REQ-034 SHALL write exactly N_VEC records, to addresses 0 .. N_VEC-1 in acceptance order; mem_addr does not wrap.
REQ-035 SHALL wrap the FIFO read and write pointers modulo DEPTH.

Reset
REQ-036 SHALL, while rst_n is low, hold state IDLE and drive in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, flag_cnt=0, with the FIFO empty.
REQ-037 SHALL, on reset assertion mid-run, discard buffered records with no further mem_we, and require a new start after release.

Verification
REQ-038 SHALL verify: N_VEC=4, start, four records (3F80,4000,4000), mem_ready=1 -> addresses 0-3 each written 3F80_4000_4000; done=1 within 3 cycles of the last accept; flag_cnt=0.
REQ-039 SHALL verify: mem_ready=0 with in_valid=1 -> exactly DEPTH=8 accepts, then in_ready=0 and mem_addr/mem_wdata stable; mem_ready=1 -> in-order drain and capture resumes.
REQ-040 SHALL verify: simultaneous push and pop with FIFO level 3 -> level stays 3 and no record is lost or duplicated.
REQ-041 SHALL verify: records with in_flags=3'b100 on 2 of 5 accepts -> flag_cnt=2 at done.
REQ-042 SHALL verify: rst_n low after 3 of 6 writes -> outputs go to reset values immediately; after release and start, writes restart at address 0.
REQ-043 SHALL verify: start pulsed during CAPTURE -> ignored; start pulsed in DONE -> new run, done=0 next cycle, flag_cnt=0.
